prbs_capture_ctrl: RTL and testbench

- Sits between the 7-bit PRBS generator and the two hex seven-segment decoders.
- Samples the free-running PRBS value into a hold register, either periodically (auto mode) or on a debounced pushbutton press (manual mode).
- Auto mode lets the user freeze and unfreeze the display with the button.
- Presents the held value as two 4-bit nibbles for SEG0 and SEG1.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/key_debounce.sv | 61 ++++++
 rtl/prbs_capture_ctrl.sv | 93 +++++++++
 tb/tb_prbs_capture_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and sizing helpers for the PRBS capture controller.
// The key path and the capture FSM both import this package.
package prbs_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } state_t;

    typedef logic [3:0] nibble_t;

    localparam logic KEY_RELEASED = 1'b1;

    // Bits needed for a counter that runs 0..cycles-1.
    function automatic int cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability debounce and a
// registered one-cycle pulse on each debounced press (releases are ignored).
module key_debounce
    import prbs_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int            CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic          deb_dly_q, deb_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = i_key_n;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        deb_dly_d = deb_q;
        press_d   = (deb_q != KEY_RELEASED) && (deb_dly_q == KEY_RELEASED);
        // The hit cycle itself is the last of DEBOUNCE_CYCLES disagreeing samples.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            sync1_q   <= KEY_RELEASED;
            sync2_q   <= KEY_RELEASED;
            deb_q     <= KEY_RELEASED;
            deb_dly_q <= KEY_RELEASED;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/prbs_capture_ctrl.sv
// Holds a PRBS sample for the two hex displays, captured periodically (auto)
// or per debounced key press (manual); in auto mode a press toggles freeze.
module prbs_capture_ctrl
    import prbs_pkg::*;
#(
    parameter int DATA_W             = 7,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int AUTO_PERIOD_CYCLES = 25000000
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_key_n,
    input  logic              i_auto,
    input  logic [DATA_W-1:0] i_randomValue,
    output nibble_t           o_lsbs,
    output nibble_t           o_msbs,
    output logic              o_update,
    output logic              o_frozen
);

    localparam int            PW       = cnt_w(AUTO_PERIOD_CYCLES);
    localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD_CYCLES - 1);

    logic              press;
    state_t            state_q, state_d;
    logic [PW-1:0]     per_q, per_d;
    logic              auto_q, auto_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic              update_q, update_d;
    logic              mode_chg, wrap, capture;
    logic [7:0]        held_ext;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_key_n (i_key_n),
        .o_press (press)
    );

    always_comb begin
        auto_d   = i_auto;
        state_d  = state_q;
        per_d    = '0;
        capture  = 1'b0;
        mode_chg = (i_auto != auto_q);
        wrap     = (per_q == PER_LAST);
        if (mode_chg) begin
            state_d = LIVE;
        end else if (!i_auto) begin
            state_d = LIVE;
            capture = press;
        end else if (state_q == LIVE) begin
            // A press landing on the wrap edge still yields a single capture and freezes.
            if (press) begin
                capture = 1'b1;
                state_d = FROZEN;
            end else begin
                capture = wrap;
                per_d   = wrap ? '0 : per_q + PW'(1);
            end
        end else if (press) begin
            state_d = LIVE;
        end
        held_d   = capture ? i_randomValue : held_q;
        update_d = capture;
    end

    // auto_q resets to auto so that powering up in auto mode starts the period cleanly.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q  <= LIVE;
            per_q    <= '0;
            auto_q   <= 1'b1;
            held_q   <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            auto_q   <= auto_d;
            held_q   <= held_d;
            update_q <= update_d;
        end
    end

    assign held_ext = 8'(held_q);
    assign o_lsbs   = held_ext[3:0];
    assign o_msbs   = held_ext[7:4];
    assign o_update = update_q;
    assign o_frozen = (state_q == FROZEN);

endmodule

// File: tb/tb_prbs_capture_ctrl.sv
// Scoreboard bench for prbs_capture_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD_CYCLES=10.
// Expected captures (edge number and nibbles) are queued by the stimulus and consumed by a monitor.
module tb_prbs_capture_ctrl;

    typedef struct {
        int cyc;
        int lsb;
        int msb;
    } exp_t;

    logic       clk;
    logic       arst;
    logic       key_n;
    logic       auto_m;
    logic [6:0] rv;
    logic [3:0] lsbs;
    logic [3:0] msbs;
    logic       update;
    logic       frozen;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

    prbs_capture_ctrl #(
        .DATA_W             (7),
        .DEBOUNCE_CYCLES    (4),
        .AUTO_PERIOD_CYCLES (10)
    ) dut (
        .i_clk         (clk),
        .i_arst        (arst),
        .i_key_n       (key_n),
        .i_auto        (auto_m),
        .i_randomValue (rv),
        .o_lsbs        (lsbs),
        .o_msbs        (msbs),
        .o_update      (update),
        .o_frozen      (frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic expect_upd(input int c, input int l, input int m);
        exp_t x;
        x.cyc = c;
        x.lsb = l;
        x.msb = m;
        exp_q.push_back(x);
    endtask

    task automatic check_outs(input string tag, input int l, input int m, input int u, input int f);
        check({tag, "_lsbs"}, int'(lsbs), l);
        check({tag, "_msbs"}, int'(msbs), m);
        check({tag, "_update"}, int'(update), u);
        check({tag, "_frozen"}, int'(frozen), f);
    endtask

    always @(negedge clk) begin
        if (update) begin
            if (exp_q.size() == 0) begin
                check("upd_unexpected_at_cycle", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_lsbs", int'(lsbs), e.lsb);
                check("upd_msbs", int'(msbs), e.msb);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("upd_missing", cyc, e.cyc);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t, c, c2, c4, c5, c6, r, r2;
        arst   = 1'b0;
        key_n  = 1'b1;
        auto_m = 1'b1;
        rv     = 7'h5A;
        tick(3);
        check_outs("reset", 0, 0, 0, 0);

        // Auto mode: periodic captures every 10 edges after reset release.
        arst = 1'b1;
        t = cyc;
        expect_upd(t + 10, 4'hA, 4'h5);
        expect_upd(t + 20, 4'hA, 4'h5);
        expect_upd(t + 30, 4'hA, 4'h5);
        wait_until(t + 35);
        check_outs("auto", 4'hA, 4'h5, 0, 0);

        // Manual mode: one capture per clean press at N+7, nothing on hold or release.
        auto_m = 1'b0;
        rv     = 7'h7F;
        wait_until(t + 38);
        c = cyc;
        key_n = 1'b0;
        expect_upd(c + 8, 4'hF, 4'h7);
        wait_until(c + 9);
        rv = 7'h11;
        wait_until(c + 20);
        key_n = 1'b1;
        wait_until(c + 40);
        check_outs("manual", 4'hF, 4'h7, 0, 0);

        // Three-cycle glitch must be rejected.
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(20);
        check_outs("glitch", 4'hF, 4'h7, 0, 0);

        // Auto again: press pulse lands on the period wrap edge.
        c = cyc;
        auto_m = 1'b1;
        rv     = 7'h23;
        expect_upd(c + 11, 4'h3, 4'h2);
        wait_until(c + 3);
        key_n = 1'b0;
        wait_until(c + 11);
        check("coinc_frozen", int'(frozen), 1);
        wait_until(c + 14);
        key_n = 1'b1;
        wait_until(c + 30);
        check_outs("frozen_hold", 4'h3, 4'h2, 0, 1);

        // Unfreeze without capture; next capture 10 edges later.
        c2 = cyc;
        rv = 7'h45;
        key_n = 1'b0;
        expect_upd(c2 + 18, 4'h5, 4'h4);
        wait_until(c2 + 7);
        check("unfreeze_before", int'(frozen), 1);
        wait_until(c2 + 8);
        check("unfreeze_after", int'(frozen), 0);
        check("unfreeze_no_upd", int'(update), 0);
        wait_until(c2 + 10);
        key_n = 1'b1;
        wait_until(c2 + 19);
        rv = 7'h66;
        expect_upd(c2 + 28, 4'h6, 4'h6);
        wait_until(c2 + 22);
        key_n = 1'b0;
        expect_upd(c2 + 30, 4'h2, 4'h1);
        wait_until(c2 + 29);
        rv = 7'h12;
        wait_until(c2 + 30);
        check("refreeze", int'(frozen), 1);
        key_n = 1'b1;
        wait_until(c2 + 45);

        // Mode toggle while frozen releases the freeze; manual mode is quiet.
        c4 = cyc;
        check("toggle_before", int'(frozen), 1);
        auto_m = 1'b0;
        wait_until(c4 + 1);
        check("toggle_after", int'(frozen), 0);
        wait_until(c4 + 51);
        check_outs("manual_quiet", 4'h2, 4'h1, 0, 0);
        c5 = cyc;
        auto_m = 1'b1;
        rv = 7'h3C;
        expect_upd(c5 + 11, 4'hC, 4'h3);
        wait_until(c5 + 12);

        // Reset mid-debounce with the key held through release.
        c6 = cyc;
        key_n = 1'b0;
        wait_until(c6 + 4);
        arst = 1'b0;
        #1;
        check_outs("rst_mid_deb", 0, 0, 0, 0);
        auto_m = 1'b0;
        rv = 7'h0B;
        tick(3);
        arst = 1'b1;
        r = cyc;
        expect_upd(r + 8, 4'hB, 4'h0);
        wait_until(r + 12);
        arst = 1'b0;
        #1;
        check_outs("rst_mid_hold", 0, 0, 0, 0);
        tick(2);
        arst = 1'b1;
        r2 = cyc;
        expect_upd(r2 + 8, 4'hB, 4'h0);
        wait_until(r2 + 12);
        key_n = 1'b1;
        wait_until(r2 + 30);
        check_outs("final", 4'hB, 4'h0, 0, 0);
        check("pending_expectations", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
